// File: rtl/compression_pkg.sv
// Shared constants, count-width helper and FSM state type for the
// compressed-stream receive path.
package compression_pkg;

  localparam int unsigned DEF_MAX_USE_BYTES = 34;
  localparam int unsigned DEF_MAX_CSE_BYTES = 34;
  localparam int unsigned DEF_SHIFT_BYTES   = 8;
  localparam int unsigned ALG_IDENTITY      = 0;
  localparam int unsigned DEF_ALGORITHM     = ALG_IDENTITY;

  typedef enum logic {
    COLLECT,
    DROP
  } state_e;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cse_byte_placer.sv
// Combinational byte placement: writes the valid low bytes of a beat into
// the assembly buffer starting at the current fill position.
module cse_byte_placer
  import compression_pkg::*;
#(
  parameter int unsigned BUF_BYTES   = DEF_MAX_CSE_BYTES,
  parameter int unsigned SHIFT_BYTES = DEF_SHIFT_BYTES,
  parameter int unsigned FILL_W      = cnt_w(DEF_MAX_CSE_BYTES),
  parameter int unsigned CNT_W       = cnt_w(DEF_SHIFT_BYTES)
) (
  input  logic [BUF_BYTES-1:0][7:0]   buf_i,
  input  logic [FILL_W-1:0]           fill_i,
  input  logic [SHIFT_BYTES-1:0][7:0] beat_i,
  input  logic [CNT_W-1:0]            cnt_i,
  output logic [BUF_BYTES-1:0][7:0]   buf_o
);

  // Bytes landing past the buffer end are dropped; the caller flags overflow.
  always_comb begin
    buf_o = buf_i;
    for (int unsigned j = 0; j < BUF_BYTES; j++) begin
      for (int unsigned i = 0; i < SHIFT_BYTES; i++) begin
        if ((i < 32'(cnt_i)) && ((32'(fill_i) + i) == j)) begin
          buf_o[j] = beat_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/decompression_module.sv
// Reassembles compressed-stream beats into full elements, applies the inverse
// compression algorithm and presents each element over valid/ready.
module decompression_module
  import compression_pkg::*;
#(
  parameter int unsigned MAX_UNCOMPRESSED_STREAM_ELEMENT_LENGTH_BYTES = DEF_MAX_USE_BYTES,
  parameter int unsigned MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES   = DEF_MAX_CSE_BYTES,
  parameter int unsigned COMPRESSIONALGORITHM                         = DEF_ALGORITHM,
  parameter int unsigned SHIFTLENGTH_BYTES                            = DEF_SHIFT_BYTES
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic [SHIFTLENGTH_BYTES-1:0][7:0]                       CSEBeatData,
  input  logic [$clog2(SHIFTLENGTH_BYTES+1)-1:0]                  CSEBeatByteCount,
  input  logic                                                    CSEBeatLast,
  input  logic                                                    CSEBeatValid,
  output logic                                                    CSEBeatReady,
  output logic [MAX_UNCOMPRESSED_STREAM_ELEMENT_LENGTH_BYTES-1:0][7:0] USEData,
  output logic [$clog2(MAX_UNCOMPRESSED_STREAM_ELEMENT_LENGTH_BYTES+1)-1:0] USEByteCount,
  output logic                                                    USEValid,
  input  logic                                                    USEReady,
  output logic                                                    Overflow
);

  localparam int unsigned MAXU   = MAX_UNCOMPRESSED_STREAM_ELEMENT_LENGTH_BYTES;
  localparam int unsigned MAXC   = MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES;
  localparam int unsigned SL_CW  = cnt_w(SHIFTLENGTH_BYTES);
  localparam int unsigned FILL_W = cnt_w(MAXC);
  localparam int unsigned NF_W   = FILL_W + 1;
  localparam int unsigned UCW    = cnt_w(MAXU);

  if (COMPRESSIONALGORITHM != ALG_IDENTITY) begin : g_bad_alg
    $error("decompression_module: unsupported COMPRESSIONALGORITHM %0d", COMPRESSIONALGORITHM);
  end

  state_e                 state_q, state_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [MAXC-1:0][7:0]   asm_q, asm_d, placed;
  logic [MAXU-1:0][7:0]   use_data_q, use_data_d, decoded;
  logic [UCW-1:0]         use_cnt_q, use_cnt_d;
  logic                   use_valid_q, use_valid_d;
  logic                   ovf_q, ovf_d;
  logic [SL_CW-1:0]       cnt_clamped;
  logic [NF_W-1:0]        nfill;
  logic                   accept;

  assign CSEBeatReady = !use_valid_q || USEReady;
  assign accept       = CSEBeatValid && CSEBeatReady;
  assign cnt_clamped  = (CSEBeatByteCount > SL_CW'(SHIFTLENGTH_BYTES)) ?
                        SL_CW'(SHIFTLENGTH_BYTES) : CSEBeatByteCount;
  assign nfill        = NF_W'(fill_q) + NF_W'(cnt_clamped);

  cse_byte_placer #(
    .BUF_BYTES  (MAXC),
    .SHIFT_BYTES(SHIFTLENGTH_BYTES),
    .FILL_W     (FILL_W),
    .CNT_W      (SL_CW)
  ) u_placer (
    .buf_i (asm_q),
    .fill_i(fill_q),
    .beat_i(CSEBeatData),
    .cnt_i (cnt_clamped),
    .buf_o (placed)
  );

  // Identity decode: bytes beyond the assembled length are already zero.
  always_comb begin
    decoded = '0;
    for (int unsigned j = 0; j < MAXU; j++) begin
      if (j < MAXC) decoded[j] = placed[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    asm_d       = asm_q;
    use_data_d  = use_data_q;
    use_cnt_d   = use_cnt_q;
    use_valid_d = use_valid_q;
    ovf_d       = 1'b0;

    if (use_valid_q && USEReady) use_valid_d = 1'b0;

    if (accept) begin
      unique case (state_q)
        COLLECT: begin
          if (32'(nfill) > MAXC) begin
            ovf_d   = 1'b1;
            asm_d   = '0;
            fill_d  = '0;
            state_d = CSEBeatLast ? COLLECT : DROP;
          end else if (CSEBeatLast) begin
            // A zero-length element clears state but produces no output.
            if (nfill != '0) begin
              use_data_d  = decoded;
              use_cnt_d   = UCW'(nfill);
              use_valid_d = 1'b1;
            end
            asm_d  = '0;
            fill_d = '0;
          end else begin
            asm_d  = placed;
            fill_d = FILL_W'(nfill);
          end
        end
        DROP: begin
          if (CSEBeatLast) begin
            state_d = COLLECT;
            fill_d  = '0;
            asm_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      fill_q      <= '0;
      asm_q       <= '0;
      use_data_q  <= '0;
      use_cnt_q   <= '0;
      use_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      asm_q       <= asm_d;
      use_data_q  <= use_data_d;
      use_cnt_q   <= use_cnt_d;
      use_valid_q <= use_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign USEData      = use_data_q;
  assign USEByteCount = use_cnt_q;
  assign USEValid     = use_valid_q;
  assign Overflow     = ovf_q;

endmodule

// File: tb/tb_decompression_module.sv
// Directed self-checking bench for decompression_module (default parameters).
module tb_decompression_module;

  localparam int SL = 8;
  localparam int MU = 34;

  logic              clk = 1'b0;
  logic              reset;
  logic [SL-1:0][7:0] CSEBeatData;
  logic [3:0]        CSEBeatByteCount;
  logic              CSEBeatLast;
  logic              CSEBeatValid;
  logic              CSEBeatReady;
  logic [MU-1:0][7:0] USEData;
  logic [5:0]        USEByteCount;
  logic              USEValid;
  logic              USEReady;
  logic              Overflow;

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;
  int v_cnt    = 0;
  int o0, v0;
  logic [271:0] tmp;

  always #5 clk = ~clk;

  decompression_module #(
    .MAX_UNCOMPRESSED_STREAM_ELEMENT_LENGTH_BYTES(34),
    .MAX_COMPRESSED_STREAM_ELEMENT_LENGTH_BYTES  (34),
    .COMPRESSIONALGORITHM                        (0),
    .SHIFTLENGTH_BYTES                           (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .CSEBeatData     (CSEBeatData),
    .CSEBeatByteCount(CSEBeatByteCount),
    .CSEBeatLast     (CSEBeatLast),
    .CSEBeatValid    (CSEBeatValid),
    .CSEBeatReady    (CSEBeatReady),
    .USEData         (USEData),
    .USEByteCount    (USEByteCount),
    .USEValid        (USEValid),
    .USEReady        (USEReady),
    .Overflow        (Overflow)
  );

  always @(negedge clk) begin
    if (Overflow === 1'b1) ov_cnt++;
    if (USEValid === 1'b1) v_cnt++;
    if (reset === 1'b1 && CSEBeatValid === 1'b1)
      assert (CSEBeatByteCount <= 4'(SL)) else begin
        failures++;
        $error("FAIL beat_count_range: got %0d required <= %0d", CSEBeatByteCount, SL);
      end
  end

  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [271:0] ev(input int n, input logic [7:0] base);
    logic [271:0] v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic send_beat(input logic [63:0] d, input int cnt, input logic last);
    int g = 0;
    CSEBeatData      = d;
    CSEBeatByteCount = 4'(cnt);
    CSEBeatLast      = last;
    CSEBeatValid     = 1'b1;
    @(negedge clk);
    while (CSEBeatReady !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (CSEBeatReady !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout: got ready=%b required 1", CSEBeatReady);
    end
    @(posedge clk);
    #1;
    CSEBeatValid     = 1'b0;
    CSEBeatLast      = 1'b0;
    CSEBeatByteCount = '0;
  endtask

  task automatic send_elem(input int n, input logic [7:0] base);
    logic [63:0] d;
    int c;
    if (n == 0) begin
      send_beat('0, 0, 1'b1);
    end else begin
      for (int off = 0; off < n; off += SL) begin
        c = (n - off < SL) ? n - off : SL;
        d = '0;
        for (int i = 0; i < c; i++) d[i*8 +: 8] = base + 8'(off + i);
        send_beat(d, c, (off + c) >= n);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; USEReady = 1'b1;
    CSEBeatData = '0; CSEBeatByteCount = '0; CSEBeatLast = 1'b0; CSEBeatValid = 1'b0;
    #12;
    chk("rst_valid", 272'(USEValid), 272'(0));
    chk("rst_count", 272'(USEByteCount), 272'(0));
    chk("rst_data", USEData, '0);
    chk("rst_ovf", 272'(Overflow), 272'(0));
    chk("rst_ready", 272'(CSEBeatReady), 272'(1));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 20-byte element in 8/8/4 beats
    send_elem(20, 8'h00);
    chk("e20_valid", 272'(USEValid), 272'(1));
    chk("e20_count", 272'(USEByteCount), 272'(20));
    chk("e20_data", USEData, ev(20, 8'h00));
    @(posedge clk); #1;
    chk("e20_retired", 272'(USEValid), 272'(0));

    // exactly MAX bytes
    o0 = ov_cnt;
    send_elem(34, 8'h40);
    chk("e34_count", 272'(USEByteCount), 272'(34));
    chk("e34_data", USEData, ev(34, 8'h40));
    chk("e34_no_ovf", 272'(Overflow), 272'(0));
    @(posedge clk); #1;
    chk("e34_ovf_cnt", 272'(ov_cnt - o0), 272'(0));

    // one byte over MAX
    v0 = v_cnt;
    send_elem(35, 8'h80);
    chk("e35_ovf", 272'(Overflow), 272'(1));
    chk("e35_no_valid", 272'(USEValid), 272'(0));
    @(posedge clk); #1;
    chk("e35_ovf_end", 272'(Overflow), 272'(0));
    chk("e35_ovf_once", 272'(ov_cnt - o0), 272'(1));
    chk("e35_no_elem", 272'(v_cnt - v0), 272'(0));
    send_elem(5, 8'hC0);
    chk("after_ovf_count", 272'(USEByteCount), 272'(5));
    chk("after_ovf_data", USEData, ev(5, 8'hC0));
    @(posedge clk); #1;

    // backpressure: element held while second one waits
    USEReady = 1'b0;
    send_elem(4, 8'h11);
    chk("bp_valid", 272'(USEValid), 272'(1));
    tmp = ev(8, 8'hA0);
    CSEBeatData = tmp[63:0]; CSEBeatByteCount = 4'd8; CSEBeatLast = 1'b1; CSEBeatValid = 1'b1;
    @(negedge clk);
    chk("bp_ready0", 272'(CSEBeatReady), 272'(0));
    @(negedge clk);
    chk("bp_ready0_b", 272'(CSEBeatReady), 272'(0));
    chk("bp_hold_data", USEData, ev(4, 8'h11));
    chk("bp_hold_count", 272'(USEByteCount), 272'(4));
    USEReady = 1'b1;
    #1;
    chk("bp_ready1", 272'(CSEBeatReady), 272'(1));
    @(posedge clk); #1;
    CSEBeatValid = 1'b0; CSEBeatLast = 1'b0;
    chk("bp_swap_valid", 272'(USEValid), 272'(1));
    chk("bp_swap_data", USEData, ev(8, 8'hA0));
    chk("bp_swap_count", 272'(USEByteCount), 272'(8));
    @(posedge clk); #1;
    chk("bp_retired", 272'(USEValid), 272'(0));

    // back-to-back single-beat elements
    v0 = v_cnt;
    for (int k = 0; k < 4; k++) begin
      tmp = ev(8, 8'(k * 16));
      CSEBeatData = tmp[63:0]; CSEBeatByteCount = 4'd8; CSEBeatLast = 1'b1; CSEBeatValid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", 272'(USEValid), 272'(1));
      chk("b2b_data", USEData, ev(8, 8'(k * 16)));
    end
    CSEBeatValid = 1'b0; CSEBeatLast = 1'b0;
    @(posedge clk); #1;
    chk("b2b_elems", 272'(v_cnt - v0), 272'(4));
    chk("b2b_done", 272'(USEValid), 272'(0));

    // zero-length element
    v0 = v_cnt; o0 = ov_cnt;
    send_elem(0, 8'h00);
    chk("zero_no_valid", 272'(USEValid), 272'(0));
    chk("zero_no_ovf", 272'(Overflow), 272'(0));
    @(posedge clk); #1;
    chk("zero_elems", 272'(v_cnt - v0), 272'(0));
    chk("zero_ovfs", 272'(ov_cnt - o0), 272'(0));

    // reset mid-element
    tmp = ev(8, 8'h50); send_beat(tmp[63:0], 8, 1'b0);
    tmp = ev(8, 8'h58); send_beat(tmp[63:0], 8, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_data", USEData, '0);
    chk("midrst_count", 272'(USEByteCount), 272'(0));
    chk("midrst_valid", 272'(USEValid), 272'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    send_elem(4, 8'hE0);
    chk("post_rst_count", 272'(USEByteCount), 272'(4));
    chk("post_rst_data", USEData, ev(4, 8'hE0));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
